// File: rtl/aes_key_expand.sv
// -----------------------------------------------------------------------------
// aes_key_expand -- AES-128 round key generator (11 round keys, idx 0..10).
//
// Accepts a 128-bit cipher key over a valid/ready handshake, then streams the
// eleven round keys over a second valid/ready handshake, one key per transfer.
//
// Handshake semantics (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. A producer holds valid and its data stable
// until the transfer; ready never depends combinationally on valid.
//
// Ports
//   clk        in   1    single clock, rising edge
//   rst_n      in   1    synchronous active-low reset
//   key_valid  in   1    cipher key offered on key_in
//   key_in     in   128  cipher key, byte 0 at [127:120], w0 at [127:96]
//   key_ready  out  1    block can accept a new key (IDLE)
//   rk_valid   out  1    rk_out holds a valid round key (EMIT)
//   rk_ready   in   1    consumer accepts rk_out
//   rk_out     out  128  current round key, same ordering as key_in
//   rk_idx     out  4    round number of rk_out
//   rk_last    out  1    rk_valid && rk_idx == 10
//   state_dbg  out  1    FSM state (0 = IDLE, 1 = EMIT)
// -----------------------------------------------------------------------------

// AES forward S-box, purely combinational lookup.
//   in_i   in   8   byte to substitute
//   out_o  out  8   substituted byte
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Entry 0 sits in the most significant byte of the first row.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_o = SBOX[in_i];

endmodule

module aes_key_expand (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'd10;

  state_e       state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;

  // ---------------------------------------------------------------------------
  // Next round key, combinational from the registered current key and rcon.
  // ---------------------------------------------------------------------------
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3, sub_w3, t_word;
  logic [31:0] n0, n1, n2, n3;
  logic [127:0] next_key;
  logic [7:0]   rcon_next;

  assign w0 = rk_q[127:96];
  assign w1 = rk_q[95:64];
  assign w2 = rk_q[63:32];
  assign w3 = rk_q[31:0];

  // RotWord: {b0,b1,b2,b3} -> {b1,b2,b3,b0}
  assign rot_w3 = {w3[23:0], w3[31:24]};

  aes_sbox u_sbox3 (.in_i(rot_w3[31:24]), .out_o(sub_w3[31:24]));
  aes_sbox u_sbox2 (.in_i(rot_w3[23:16]), .out_o(sub_w3[23:16]));
  aes_sbox u_sbox1 (.in_i(rot_w3[15:8]),  .out_o(sub_w3[15:8]));
  aes_sbox u_sbox0 (.in_i(rot_w3[7:0]),   .out_o(sub_w3[7:0]));

  assign t_word   = sub_w3 ^ {rcon_q, 24'h000000};
  assign n0       = w0 ^ t_word;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // xtime in GF(2^8): 01,02,04,...,80,1b,36
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  // ---------------------------------------------------------------------------
  // FSM next state / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          state_d = EMIT;
          rk_d    = key_in;
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (idx_q == LAST_IDX) begin
            // Last key consumed: keep rk/idx visible, go back to IDLE.
            // key_ready is still 0 this cycle, so no key is accepted now.
            state_d = IDLE;
          end else begin
            rk_d   = next_key;
            idx_d  = idx_q + 4'd1;
            rcon_d = rcon_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rk_q    <= 128'h0;
      idx_q   <= 4'd0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
    end
  end

  // All outputs decoded from registers only.
  assign key_ready = (state_q == IDLE);
  assign rk_valid  = (state_q == EMIT);
  assign rk_out    = rk_q;
  assign rk_idx    = idx_q;
  assign rk_last   = (state_q == EMIT) && (idx_q == LAST_IDX);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// -----------------------------------------------------------------------------
// tb_aes_key_expand -- directed and randomized bench for aes_key_expand.
// Reference round keys come from a FIPS-197 style word expansion whose S-box is
// derived from GF(2^8) inversion plus the affine transform.
// -----------------------------------------------------------------------------
module tb_aes_key_expand;

  logic         clk;
  logic         rst_n;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         state_dbg;

  int errors = 0;
  int checks = 0;

  logic [127:0] exp_q[$];
  logic [127:0] cap [11];
  logic [7:0]   sb_m [256];

  aes_key_expand dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_in    (key_in),
    .key_ready (key_ready),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_out    (rk_out),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox_model();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] bx  = 8'(x);
      for (int y = 1; y < 256; y++)
        if (gmul(bx, 8'(y)) == 8'h01) inv = 8'(y);
      sb_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    exp_q.delete();
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_m[t[31:24]], sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      exp_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard compare
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: offer key, consume its round keys. Entered and left at a negedge.
  //   mode 0: rk_ready always 1; mode 1: random with 5-cycle stalls at 0/9/10
  //   intr_idx: pulse key_valid with another key for one cycle at that idx
  //   abort_idx: return as soon as that idx is shown (caller resets)
  //   hold: keep key_valid high, presenting next_key after the accept
  // ---------------------------------------------------------------------------
  task automatic expand(input logic [127:0] key, input int mode, input int intr_idx,
                        input int abort_idx, input bit hold, input logic [127:0] next_key);
    int idx = 0;
    int cycles = 0;
    int stall_left = 0;
    int last_seen = -1;
    bit intr_on = 0;
    bit aborted = 0;
    logic [127:0] last_key = '0;
    model_expand(key);
    chk("accept_ready", 128'(key_ready), 128'(1));
    chk("accept_idle_valid", 128'(rk_valid), 128'(0));
    key_valid = 1'b1;
    key_in    = key;
    @(negedge clk);
    if (hold) key_in = next_key;
    else      key_valid = 1'b0;
    while (idx <= 10 && cycles < 400) begin
      cycles++;
      if (idx == abort_idx) begin
        aborted = 1;
        break;
      end
      chk("rk_valid", 128'(rk_valid), 128'(1));
      chk("key_ready_busy", 128'(key_ready), 128'(0));
      chk($sformatf("rk_out_idx%0d", idx), rk_out, exp_q[0]);
      chk("rk_idx", 128'(rk_idx), 128'(idx));
      chk("rk_last", 128'(rk_last), 128'(idx == 10));
      if (intr_on) begin
        key_valid = 1'b0;
        intr_on   = 0;
      end
      if (idx == intr_idx && last_seen != idx) begin
        key_valid = 1'b1;
        key_in    = rand128();
        intr_on   = 1;
      end
      if (mode == 1 && idx != last_seen && (idx == 0 || idx == 9 || idx == 10))
        stall_left = 5;
      last_seen = idx;
      if (stall_left > 0) begin
        rk_ready = 1'b0;
        stall_left--;
      end else begin
        rk_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      if (rk_ready) begin
        cap[idx] = rk_out;
        last_key = rk_out;
        exp_q.delete(0);
        idx++;
      end
      @(negedge clk);
    end
    if (!aborted) begin
      rk_ready = 1'b0;
      chk("keys_done", 128'(idx), 128'(11));
      chk("post_valid", 128'(rk_valid), 128'(0));
      chk("post_key_ready", 128'(key_ready), 128'(1));
      chk("post_last", 128'(rk_last), 128'(0));
      chk("post_idx_hold", 128'(rk_idx), 128'(10));
      chk("post_out_hold", rk_out, last_key);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [127:0] ka, kb;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    rk_ready  = 1'b0;
    build_sbox_model();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(rk_valid), 128'(0));
    chk("rst_key_ready", 128'(key_ready), 128'(1));
    chk("rst_out", rk_out, 128'h0);
    chk("rst_idx", 128'(rk_idx), 128'(0));
    chk("rst_last", 128'(rk_last), 128'(0));
    chk("rst_state", 128'(state_dbg), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 key, no backpressure
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 0, -1, -1, 0, '0);
    chk("fips_idx0", cap[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("fips_idx1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_idx10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // All-zero key
    expand(128'h0, 0, -1, -1, 0, '0);
    chk("zero_idx1", cap[1], 128'h62636363626363636263636362636363);
    chk("zero_idx10", cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Backpressure with forced stalls
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 1, -1, -1, 0, '0);
    chk("bp_idx10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Intruding key at idx 4 is ignored; not re-accepted once withdrawn
    expand(rand128(), 0, 4, -1, 0, '0);
    @(negedge clk);
    chk("intr_not_accepted", 128'(rk_valid), 128'(0));

    // Reset mid-stream at idx 6, key offered during reset
    expand(rand128(), 0, -1, 6, 0, '0);
    rst_n     = 1'b0;
    key_valid = 1'b1;
    key_in    = rand128();
    rk_ready  = 1'b1;
    @(negedge clk);
    chk("abort_valid", 128'(rk_valid), 128'(0));
    chk("abort_out", rk_out, 128'h0);
    chk("abort_idx", 128'(rk_idx), 128'(0));
    chk("abort_key_ready", 128'(key_ready), 128'(1));
    chk("abort_last", 128'(rk_last), 128'(0));
    @(negedge clk);
    chk("rst_no_accept", 128'(rk_valid), 128'(0));
    rst_n     = 1'b1;
    key_valid = 1'b0;
    rk_ready  = 1'b0;
    expand(rand128(), 0, -1, -1, 0, '0);

    // Back-to-back keys with key_valid held high
    ka = rand128();
    kb = rand128();
    expand(ka, 0, -1, -1, 1, kb);
    expand(kb, 0, -1, -1, 0, '0);

    // Random keys with random backpressure
    for (int n = 0; n < 4; n++) expand(rand128(), 1, -1, -1, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 The block SHALL have no parameters; it SHALL implement AES-128 only (11 round keys, indices 0..10).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 key_valid  input  1  cipher key on key_in is offered.
REQ-005 key_in  input  128  AES-128 cipher key; byte 0 at [127:120], word w0 at [127:96].
REQ-006 key_ready  output  1  block can accept a new key.
REQ-007 rk_valid  output  1  rk_out holds a valid round key.
REQ-008 rk_ready  input  1  consumer (AddRoundKey stage) accepts rk_out.
REQ-009 rk_out  output  128  current round key; same byte/word ordering as key_in.
REQ-010 rk_idx  output  4  round number of rk_out, 0..10.
REQ-011 rk_last  output  1  high exactly when rk_valid=1 and rk_idx=10.

Function
REQ-012 The FSM SHALL have two states: IDLE (key_ready=1, rk_valid=0) and EMIT (key_ready=0, rk_valid=1).
REQ-013 Key accept: key_valid=1 and key_ready=1 in IDLE; next cycle SHALL be EMIT with rk_out=key_in, rk_idx=0 (latency 1 cycle).
REQ-014 key_valid SHALL be ignored in EMIT; key_in SHALL be sampled only on the accept cycle.
REQ-015 Transfer: rk_valid=1 and rk_ready=1; on transfer with rk_idx<10, next cycle rk_out SHALL be the next round key and rk_idx SHALL increment by 1.
REQ-016 Stall: with rk_valid=1 and rk_ready=0, rk_out, rk_idx and rk_last SHALL hold stable.
REQ-017 Next key from current words w0..w3: t = SubWord(RotWord(w3)) XOR {rcon,24'h0}; n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
REQ-018 RotWord SHALL rotate bytes left by one ({b0,b1,b2,b3} -> {b1,b2,b3,b0}); SubWord SHALL apply the AES S-box to each of the 4 bytes, using 4 instances of the team's existing S-box.
REQ-019 rcon SHALL be an 8-bit register set to 8'h01 on key accept and updated on each transfer as GF(2^8) xtime: (rcon<<1) XOR (rcon[7] ? 8'h1B : 8'h00), giving 01,02,04,08,10,20,40,80,1B,36.
REQ-020 Next-key computation SHALL be combinational from registered state, so with rk_ready held high one key SHALL transfer per cycle: 11 consecutive rk_valid cycles.
REQ-021 On transfer with rk_idx=10 (rk_last=1), next state SHALL be IDLE: rk_valid=0 and key_ready=1 the following cycle; a new key SHALL NOT be accepted in the rk_last transfer cycle.
REQ-022 In IDLE, rk_out and rk_idx SHALL hold their last values; rk_last SHALL be 0.
REQ-023 All outputs SHALL be registered or decoded purely from registers; no combinational path from any input to any output.

Reset
REQ-024 With rst_n=0 at a clock edge: state=IDLE, rk_valid=0, key_ready=1 after the edge, rk_out=128'h0, rk_idx=0, rk_last=0, rcon=8'h01.
REQ-025 Reset SHALL take priority over any handshake in the same cycle and SHALL abort an expansion mid-stream with no further rk_valid.
REQ-026 While rst_n=0, key_ready SHALL read 1 but no key SHALL be accepted.

Verification
REQ-027 Key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> idx0 = key, idx1 = a0fafe1788542cb123a339392a6c7605, idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6, 11 consecutive valid cycles, rk_last only on idx10.
REQ-028 Key 128'h0 -> idx1 = 62636363626363636263636362636363, idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-029 Backpressure: random rk_ready (include 5-cycle stalls at idx0, idx9 and idx10) -> identical key sequence as REQ-027, outputs stable during every stall.
REQ-030 Second key_valid pulse with different key at idx 4 -> ignored; sequence completes unchanged; the key is accepted only if still offered after key_ready returns high.
REQ-031 rst_n=0 for one cycle at idx 6 -> rk_valid=0, rk_out=0, rk_idx=0, key_ready=1 next cycle; a new key then expands correctly from idx 0.
REQ-032 Back-to-back keys with key_valid held high -> second key accepted exactly one cycle after the rk_last transfer; its idx0 appears on the following cycle.
